// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, ALU/result encodings, ID/EX control-word layout
// and the immediate generator.
package riscv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_AND    = 4'd2,
    ALU_OR     = 4'd3,
    ALU_XOR    = 4'd4,
    ALU_SLT    = 4'd5,
    ALU_SLTU   = 4'd6,
    ALU_SLL    = 4'd7,
    ALU_SRL    = 4'd8,
    ALU_SRA    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // Ctrl word: {RegWrite,MemRead,MemWrite,ALUSrc,ResultSrc[1:0],Branch,Jump,ALUControl[3:0]}
  localparam int unsigned CTRL_W        = 12;
  localparam int unsigned CTRL_REGWRITE = 11;
  localparam int unsigned CTRL_MEMREAD  = 10;
  localparam int unsigned CTRL_MEMWRITE = 9;
  localparam int unsigned CTRL_ALUSRC   = 8;
  localparam int unsigned CTRL_RESSRC   = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_JUMP     = 4;
  localparam int unsigned CTRL_ALUCTRL  = 0;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  function automatic logic [XLEN-1:0] gen_imm(input imm_sel_e sel, input logic [31:0] inst);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (sel)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32 x XLEN register file, two combinational read ports, one synchronous write port.
// x0 reads as zero; a same-cycle writeback is bypassed to the read ports.
module reg_file
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [4:0]      wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wr_ok;

  assign wr_ok = we && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wa] <= wd;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (wr_ok && wa == ra1) ? wd : regs[ra1];
    if (ra2 != '0) rd2 = (wr_ok && wa == ra2) ? wd : regs[ra2];
  end

endmodule

// File: rtl/id_hazard.sv
// RV32I decode stage: decode, register read, immediate generation, load-use hazard
// detection and the ID/EX pipeline register (stalls are realised as bubbles).
module id_hazard
  import riscv_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         Instruc_IFID,
  input  logic [XLEN-1:0]     PC_IFID,
  input  logic                flush_ID,
  input  logic                RegWrite_WB,
  input  logic [4:0]          Rd_WB,
  input  logic [XLEN-1:0]     Result_WB,
  output logic                PCWrite,
  output logic                Write_IFID,
  output logic [XLEN-1:0]     PC_IDEX,
  output logic [XLEN-1:0]     RD1_IDEX,
  output logic [XLEN-1:0]     RD2_IDEX,
  output logic [XLEN-1:0]     Imm_IDEX,
  output logic [4:0]          Rs1_IDEX,
  output logic [4:0]          Rs2_IDEX,
  output logic [4:0]          Rd_IDEX,
  output logic [CTRL_W-1:0]   Ctrl_IDEX,
  output logic [2:0]          Funct3_IDEX,
  output logic                Illegal_IDEX
);

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              alt;
  logic [4:0]        rs1_f, rs2_f, rd_f;

  logic [CTRL_W-1:0] ctrl_d;
  imm_sel_e          imm_sel;
  logic              uses_rs1, uses_rs2, has_f3, illegal_d;
  logic [4:0]        rs1_d, rs2_d, rd_d;
  logic [XLEN-1:0]   rd1_d, rd2_d, imm_d;
  logic              stall, bubble;

  assign opcode = Instruc_IFID[6:0];
  assign rd_f   = Instruc_IFID[11:7];
  assign funct3 = Instruc_IFID[14:12];
  assign rs1_f  = Instruc_IFID[19:15];
  assign rs2_f  = Instruc_IFID[24:20];
  assign alt    = Instruc_IFID[30];

  function automatic alu_ctrl_e alu_sel(input logic [2:0] f3, input logic alt_b, input logic sub_ok);
    alu_ctrl_e op;
    case (f3)
      3'b000:  op = (sub_ok && alt_b) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt_b ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    ctrl_d    = '0;
    imm_sel   = IMM_NONE;
    uses_rs1  = 1'b1;
    uses_rs2  = 1'b0;
    has_f3    = 1'b0;
    illegal_d = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_ALUCTRL +: 4]  = alu_sel(funct3, alt, 1'b1);
        uses_rs2                   = 1'b1;
        has_f3                     = 1'b1;
      end
      OP_I: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = alu_sel(funct3, alt, 1'b0);
        imm_sel                    = IMM_I;
        has_f3                     = 1'b1;
      end
      OP_LOAD: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_MEMREAD]       = 1'b1;
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_RESSRC +: 2]   = RES_MEM;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_ADD;
        imm_sel                    = IMM_I;
        has_f3                     = 1'b1;
      end
      OP_STORE: begin
        ctrl_d[CTRL_MEMWRITE]      = 1'b1;
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_ADD;
        imm_sel                    = IMM_S;
        uses_rs2                   = 1'b1;
        has_f3                     = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_d[CTRL_BRANCH]        = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_SUB;
        imm_sel                    = IMM_B;
        uses_rs2                   = 1'b1;
        has_f3                     = 1'b1;
      end
      OP_JAL: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_RESSRC +: 2]   = RES_PC4;
        ctrl_d[CTRL_JUMP]          = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_ADD;
        imm_sel                    = IMM_J;
        uses_rs1                   = 1'b0;
      end
      OP_JALR: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_RESSRC +: 2]   = RES_PC4;
        ctrl_d[CTRL_JUMP]          = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_ADD;
        imm_sel                    = IMM_I;
        has_f3                     = 1'b1;
      end
      OP_LUI: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_PASS_B;
        imm_sel                    = IMM_U;
        uses_rs1                   = 1'b0;
      end
      OP_AUIPC: begin
        ctrl_d[CTRL_REGWRITE]      = (rd_f != '0);
        ctrl_d[CTRL_ALUSRC]        = 1'b1;
        ctrl_d[CTRL_ALUCTRL +: 4]  = ALU_ADD;
        imm_sel                    = IMM_U;
        uses_rs1                   = 1'b0;
      end
      // All-zero word is a flushed IF/ID slot, not an illegal instruction
      default: illegal_d = (Instruc_IFID != '0);
    endcase
  end

  // Unused source fields are zeroed so EX forwarding never matches on immediate bits
  assign rs1_d = uses_rs1 ? rs1_f : '0;
  assign rs2_d = uses_rs2 ? rs2_f : '0;
  assign rd_d  = ctrl_d[CTRL_REGWRITE] ? rd_f : '0;
  assign imm_d = gen_imm(imm_sel, Instruc_IFID);

  reg_file u_reg_file (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_d),
    .ra2 (rs2_d),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (RegWrite_WB),
    .wa  (Rd_WB),
    .wd  (Result_WB)
  );

  assign stall = Ctrl_IDEX[CTRL_MEMREAD] && (Rd_IDEX != '0) &&
                 ((uses_rs1 && Rd_IDEX == rs1_f) || (uses_rs2 && Rd_IDEX == rs2_f));
  assign bubble     = stall || flush_ID;
  assign PCWrite    = !(stall && !flush_ID);
  assign Write_IFID = !(stall && !flush_ID);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      PC_IDEX      <= '0;
      RD1_IDEX     <= '0;
      RD2_IDEX     <= '0;
      Imm_IDEX     <= '0;
      Rs1_IDEX     <= '0;
      Rs2_IDEX     <= '0;
      Rd_IDEX      <= '0;
      Ctrl_IDEX    <= '0;
      Funct3_IDEX  <= '0;
      Illegal_IDEX <= 1'b0;
    end else begin
      PC_IDEX      <= PC_IFID;
      RD1_IDEX     <= rd1_d;
      RD2_IDEX     <= rd2_d;
      Imm_IDEX     <= imm_d;
      Rs1_IDEX     <= rs1_d;
      Rs2_IDEX     <= rs2_d;
      Rd_IDEX      <= rd_d;
      Ctrl_IDEX    <= ctrl_d;
      Funct3_IDEX  <= has_f3 ? funct3 : 3'b000;
      Illegal_IDEX <= illegal_d;
    end
  end

endmodule
